arb_wrr_packet_mux: RTL
=======================

Name: arb_wrr_packet_mux

Overview:
- Downstream consumer of the weighted round-robin arbiter's one-hot grant.
- Drives the arbiter's request vector from per-client valid/ready channels and muxes the granted client's payload into a single registered output channel.
- Holds ownership for multi-beat packets until the last beat, so packets are never interleaved.
- Drives the arbiter's block input so credits are charged only on beats actually transferred.

Parameters:
- CLIENTS, 4, number of requesting clients
- DATA_WIDTH, 32, payload width per client
- ID_WIDTH, $clog2(CLIENTS) (min 1), width of output client index

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_valid  in  CLIENTS  per-client beat valid
- i_data  in  CLIENTS*DATA_WIDTH  per-client payload, client k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_last  in  CLIENTS  per-client last-beat-of-packet flag
- o_ready  out  CLIENTS  per-client beat accepted (combinational)
- o_arb_req  out  CLIENTS  request vector to arbiter
- o_arb_block  out  1  block input to arbiter
- i_arb_grant  in  CLIENTS  one-hot grant from arbiter (combinational w.r.t. o_arb_req)
- o_out_valid  out  1  registered output valid
- o_out_data  out  DATA_WIDTH  registered output payload
- o_out_id  out  ID_WIDTH  index of the source client
- o_out_last  out  1  registered last flag
- i_out_ready  in  1  downstream ready
- o_locked  out  1  high while a packet is in progress (state LOCK)

Behaviour:
- Reset: i_rst_n asynchronous, active-low; clock i_clk. On reset: state=ARB, r_owner=0, o_out_valid=0, o_out_data=0, o_out_id=0, o_out_last=0, o_locked=0.
- Mid-packet reset discards the owner and any held beat; there is no recovery of partial packets.
- Accept condition: w_acc = !o_out_valid || i_out_ready. This gives full throughput of one beat per cycle. The combinational path i_out_ready -> o_arb_block -> i_arb_grant -> o_ready is permitted.
- o_arb_req = i_valid in all states.
- State ARB:
  - o_arb_block = !w_acc.
  - Effective grant g = i_arb_grant & i_valid. Non-one-hot g is an assertion error; the implementation selects the lowest set bit.
  - If w_acc && g!=0, with sel = index of g:
    - o_ready[sel]=1.
    - Output register loads i_data[sel], sel, i_last[sel]; o_out_valid<=1.
    - If i_last[sel]=0, go to LOCK with r_owner<=sel. Otherwise stay in ARB.
- State LOCK:
  - o_arb_block=1 unconditionally; the arbiter neither grants nor charges credit.
  - If w_acc && i_valid[r_owner]:
    - o_ready[r_owner]=1.
    - Output register loads that client's beat.
    - If i_last[r_owner]=1, go to ARB.
  - If i_valid[r_owner] is low, hold LOCK (bubble). No timeout.
- All other o_ready bits are 0 every cycle.
- If w_acc and no beat is captured: o_out_valid<=0 when i_out_ready, otherwise hold.
- When o_out_valid && !i_out_ready, all output fields hold stable; this is a valid/ready protocol requirement.
- Latency: a beat appears on o_out_* the cycle after its o_ready pulse.
- A single-beat packet (i_last=1 on the first beat) never enters LOCK.
- Back-to-back single-beat packets from different clients can be accepted on consecutive cycles.
- Last beat and a new arbitration: the cycle of the LOCK->ARB transition does not arbitrate. The next grant is accepted the following cycle.
- o_locked = (state==LOCK).

Decomposition:
- Shared package arb_pkg:
  - typedef enum logic {ARB, LOCK} arb_lock_state_t.
  - Function onehot_to_idx(CLIENTS-bit vector) returning the lowest set index.
- One sub-module: arb_out_reg. It holds the output register with the valid/ready hold logic. Inputs are load-enable, data, id and last; it exports w_acc.
- The arbiter itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset mid-packet: client 1 has sent 2 of 4 beats and reset asserts -> all outputs 0 and state ARB immediately. After release, client 1's remaining beats arbitrate as a new packet.
- Single-beat, all clients: CLIENTS=4, all i_valid=1, i_last=1, grant rotating 0,1,2,3, i_out_ready=1 -> o_out_id sequence 0,1,2,3 on consecutive cycles, one o_ready pulse per cycle, o_locked stays 0.
- Multi-beat lock: client 2 sends 3 beats (last on beat 3) while client 0 is valid and the grant tries to move to 0 -> o_arb_block=1 for beats 2-3, o_out_id=2 for 3 consecutive beats, then client 0's beat appears 2 cycles after beat 3.
- Backpressure: o_out_valid=1 with i_out_ready=0 for 5 cycles -> o_out_data/id/last stable, o_arb_block=1, o_ready=0. On ready=1, the next beat is accepted the same cycle.
- Owner bubble: client 3 in LOCK drops i_valid for 2 cycles while client 1 is valid -> no client 1 beat accepted and o_out_valid=0 during the gap. Client 3 resumes and completes its packet.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and helpers for the WRR packet mux.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int c_MAX_CLIENTS = 32;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_lock_state_t;

    // Lowest set index of a (nominally one-hot) request/grant vector.
    function automatic int onehot_to_idx(input logic [c_MAX_CLIENTS-1:0] vec);
        int idx;
        idx = 0;
        for (int i = c_MAX_CLIENTS - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : arb_out_reg
// Description : Single-entry registered valid/ready output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ID_WIDTH-1:0]   i_id,
    input  logic                  i_last,
    input  logic                  i_out_ready,
    output logic                  o_acc,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [ID_WIDTH-1:0]   o_out_id,
    output logic                  o_out_last
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_last;

    // Slot is free when empty or being drained this cycle.
    assign o_acc = !r_valid || i_out_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_last  <= 1'b0;
        end else if (i_load && o_acc) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_id    <= i_id;
            r_last  <= i_last;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;
    assign o_out_id    = r_id;
    assign o_out_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/arb_wrr_packet_mux.sv
`default_nettype none
// ============================================================================
// Module      : arb_wrr_packet_mux
// Description : Packet-atomic mux driven by an external WRR arbiter grant.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_wrr_packet_mux
    import arb_pkg::*;
#(
    parameter int CLIENTS    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [CLIENTS-1:0]            i_valid,
    input  logic [CLIENTS*DATA_WIDTH-1:0] i_data,
    input  logic [CLIENTS-1:0]            i_last,
    output logic [CLIENTS-1:0]            o_ready,
    output logic [CLIENTS-1:0]            o_arb_req,
    output logic                          o_arb_block,
    input  logic [CLIENTS-1:0]            i_arb_grant,
    output logic                          o_out_valid,
    output logic [DATA_WIDTH-1:0]         o_out_data,
    output logic [ID_WIDTH-1:0]           o_out_id,
    output logic                          o_out_last,
    input  logic                          i_out_ready,
    output logic                          o_locked
);

    arb_lock_state_t           r_state;
    arb_lock_state_t           w_state_nxt;
    logic [ID_WIDTH-1:0]       r_owner;
    logic [CLIENTS-1:0]        w_grant_eff;
    logic [c_MAX_CLIENTS-1:0]  w_grant_ext;
    logic [ID_WIDTH-1:0]       w_sel;
    logic [ID_WIDTH-1:0]       w_src;
    int                        w_src_base;
    logic                      w_acc;
    logic                      w_load;
    logic [CLIENTS-1:0]        w_ready;

    assign w_grant_eff = i_arb_grant & i_valid;

    always_comb begin
        w_grant_ext              = '0;
        w_grant_ext[CLIENTS-1:0] = w_grant_eff;
    end

    assign w_sel      = ID_WIDTH'(onehot_to_idx(w_grant_ext));
    // While locked the owner, not the arbiter, selects the source.
    assign w_src      = (r_state == LOCK) ? r_owner : w_sel;
    assign w_src_base = int'(w_src) * DATA_WIDTH;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_load      = 1'b0;
        o_arb_block = 1'b1;
        case (r_state)
            ARB: begin
                o_arb_block = !w_acc;
                if (w_acc && (|w_grant_eff)) begin
                    w_ready[w_src] = 1'b1;
                    w_load         = 1'b1;
                    if (!i_last[w_src]) w_state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (w_acc && i_valid[w_src]) begin
                    w_ready[w_src] = 1'b1;
                    w_load         = 1'b1;
                    if (i_last[w_src]) w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ARB;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB && w_state_nxt == LOCK) r_owner <= w_sel;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && r_state == ARB) assert ($onehot0(w_grant_eff));
    end

    arb_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_out_reg (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_load),
        .i_data      (i_data[w_src_base +: DATA_WIDTH]),
        .i_id        (w_src),
        .i_last      (i_last[w_src]),
        .i_out_ready (i_out_ready),
        .o_acc       (w_acc),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .o_out_id    (o_out_id),
        .o_out_last  (o_out_last)
    );

    assign o_ready   = w_ready;
    assign o_arb_req = i_valid;
    assign o_locked  = (r_state == LOCK);

endmodule
`default_nettype wire
